// File: rtl/core_btb_assoc.sv
// Set-associative branch target buffer for the fetch stage.
// Combinational lookup by fetch PC, hit-or-allocate update with per-set
// round-robin replacement, single-entry invalidate and a one-set-per-cycle
// full-flush sweep.
module core_btb_assoc #(
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2,
  parameter int TAG_W   = 11,
  parameter int TYPE_W  = 2,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              PHT_pred_taken,
  input  logic              update_v,
  input  logic              update_inval,
  input  logic [31:0]       update_pc,
  input  logic [31:0]       update_target,
  input  logic [TYPE_W-1:0] update_type,
  input  logic              flush_req,
  output logic              btb_v,
  output logic [31:0]       btb_target_out,
  output logic [TYPE_W-1:0] btb_type_out,
  output logic [WAY_W-1:0]  btb_way_out,
  output logic              en_btb_pred,
  output logic              flush_busy
);

  localparam int SETS = 1 << INDEX_W;
  // PC bits that actually participate in index/tag
  localparam logic [31:0] PC_USED =
    32'((64'd1 << (INDEX_W + TAG_W + 2)) - 64'd1) & 32'hFFFF_FFFC;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] sweep_reg, sweep_next;

  logic [WAYS-1:0]    valid_reg [SETS];

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic [WAYS-1:0]    lk_hit, up_hit;
  logic [29:0]        way_target [WAYS];
  logic [TYPE_W-1:0]  way_type [WAYS];

  logic [WAY_W-1:0]   lk_way;
  logic [WAY_W-1:0]   rr_cur;
  logic [WAY_W-1:0]   up_hit_way, alloc_way, write_way;
  logic               up_apply, up_any_hit, up_free, up_write, rr_adv;
  logic               unused_bits;

  assign lk_idx = pc[INDEX_W+1:2];
  assign lk_tag = pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign up_idx = update_pc[INDEX_W+1:2];
  assign up_tag = update_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  // Address bits outside index/tag and the target's byte offset carry no state
  assign unused_bits = ^{pc & ~PC_USED, update_pc & ~PC_USED, update_target[1:0]};

  // Per-way tag/target/type storage and the two tag comparators (lookup, update)
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem    [SETS];
      logic [29:0]       target_mem [SETS];
      logic [TYPE_W-1:0] type_mem   [SETS];

      assign lk_hit[gi]     = valid_reg[lk_idx][gi] && (tag_mem[lk_idx] == lk_tag);
      assign up_hit[gi]     = valid_reg[up_idx][gi] && (tag_mem[up_idx] == up_tag);
      assign way_target[gi] = target_mem[lk_idx];
      assign way_type[gi]   = type_mem[lk_idx];

      // Payload write for this way; contents are don't-care until valid is set
      always_ff @(posedge clk) begin
        if (up_write && (write_way == WAY_W'(gi))) begin
          tag_mem[up_idx]    <= up_tag;
          target_mem[up_idx] <= update_target[31:2];
          type_mem[up_idx]   <= update_type;
        end
      end
    end

    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_reg [SETS];

      // Round-robin victim pointer per set: cleared by reset and sweep,
      // advanced only when a full set forces a replacement
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SETS; i++) rr_reg[i] <= '0;
        end else if (state_reg == FLUSH) begin
          rr_reg[sweep_reg] <= '0;
        end else if (rr_adv) begin
          rr_reg[up_idx] <= rr_reg[up_idx] + WAY_W'(1);
        end
      end

      assign rr_cur = rr_reg[up_idx];
    end else begin : g_no_rr
      assign rr_cur = '0;
    end
  endgenerate

  // Update decode: hit way, lowest invalid way, and the way to be written
  always_comb begin
    up_apply   = update_v && (state_reg == IDLE);
    up_any_hit = |up_hit;
    up_hit_way = '0;
    alloc_way  = rr_cur;
    up_free    = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (up_hit[i]) up_hit_way = WAY_W'(i);
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!up_free && !valid_reg[up_idx][i]) begin
        alloc_way = WAY_W'(i);
        up_free   = 1'b1;
      end
    end
    up_write  = up_apply && !update_inval;
    write_way = up_any_hit ? up_hit_way : alloc_way;
    rr_adv    = up_write && !up_any_hit && !up_free;
  end

  // Valid bits: reset/sweep clear, invalidate on hit, set on allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) valid_reg[i] <= '0;
    end else if (state_reg == FLUSH) begin
      valid_reg[sweep_reg] <= '0;
    end else if (up_apply) begin
      if (update_inval) begin
        if (up_any_hit) valid_reg[up_idx][up_hit_way] <= 1'b0;
      end else begin
        valid_reg[up_idx][write_way] <= 1'b1;
      end
    end
  end

  // Flush FSM state and sweep counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  // Flush FSM next state: one set cleared per cycle, exit after the last set
  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
          sweep_next = '0;
        end
      end
      FLUSH: begin
        if (&sweep_reg) begin
          state_next = IDLE;
          sweep_next = '0;
        end else begin
          sweep_next = sweep_reg + INDEX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        sweep_next = '0;
      end
    endcase
  end

  // Lookup result: hit way select, outputs forced to zero on miss or during sweep
  always_comb begin
    lk_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (lk_hit[i]) lk_way = WAY_W'(i);
    end
    btb_v          = (|lk_hit) && (state_reg == IDLE);
    btb_target_out = btb_v ? {way_target[lk_way], 2'b00} : 32'd0;
    btb_type_out   = btb_v ? way_type[lk_way] : '0;
    btb_way_out    = btb_v ? lk_way : '0;
    en_btb_pred    = btb_v && PHT_pred_taken;
    flush_busy     = (state_reg == FLUSH);
  end

endmodule

// File: tb/tb_core_btb_assoc.sv
// Self-checking bench for core_btb_assoc (default parameters: 64 sets, 2 ways).
// Lookup expectations are queued as stimulus is driven and compared at the
// following negative edge.
module tb_core_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        PHT_pred_taken;
  logic        update_v;
  logic        update_inval;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic [1:0]  update_type;
  logic        flush_req;
  logic        btb_v;
  logic [31:0] btb_target_out;
  logic [1:0]  btb_type_out;
  logic [0:0]  btb_way_out;
  logic        en_btb_pred;
  logic        flush_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] tgt;
    logic [1:0]  typ;
    logic        way;
    logic        pred;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  core_btb_assoc dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .PHT_pred_taken (PHT_pred_taken),
    .update_v       (update_v),
    .update_inval   (update_inval),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_type    (update_type),
    .flush_req      (flush_req),
    .btb_v          (btb_v),
    .btb_target_out (btb_target_out),
    .btb_type_out   (btb_type_out),
    .btb_way_out    (btb_way_out),
    .en_btb_pred    (en_btb_pred),
    .flush_busy     (flush_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // One lookup cycle: queue the expectation, compare at negedge, advance past posedge
  task automatic look(input string name, input logic [31:0] pcv, input logic pht,
                      input logic ev, input logic [31:0] et, input logic [1:0] ety,
                      input logic ew);
    exp_t e;
    pc             = pcv;
    PHT_pred_taken = pht;
    e.name = name; e.v = ev; e.tgt = et; e.typ = ety; e.way = ew;
    e.pred = ev & pht; e.busy = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".v"},    32'(btb_v),          32'(e.v));
      chk({e.name, ".tgt"},  btb_target_out,      e.tgt);
      chk({e.name, ".type"}, 32'(btb_type_out),   32'(e.typ));
      chk({e.name, ".way"},  32'(btb_way_out),    32'(e.way));
      chk({e.name, ".pred"}, 32'(en_btb_pred),    32'(e.pred));
      chk({e.name, ".busy"}, 32'(flush_busy),     32'(e.busy));
      $display("look %-10s pc=%08h v=%0d tgt=%08h type=%0d way=%0d pred=%0d",
               e.name, pcv, btb_v, btb_target_out, btb_type_out, btb_way_out, en_btb_pred);
    end
    @(posedge clk); #1;
  endtask

  task automatic miss(input string name, input logic [31:0] pcv);
    look(name, pcv, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] tgt,
                     input logic [1:0] typ, input logic inval);
    update_v = 1'b1; update_pc = upc; update_target = tgt;
    update_type = typ; update_inval = inval;
    @(posedge clk); #1;
    update_v = 1'b0; update_inval = 1'b0;
    $display("upd  pc=%08h tgt=%08h type=%0d inval=%0d", upc, tgt, typ, inval);
  endtask

  // Count busy cycles after a flush pulse; drops an update mid-sweep and
  // optionally asserts reset once the count reaches rst_at
  task automatic flush_run(input int rst_at, output int cnt);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!flush_busy) break;
      cnt++;
      if (cnt == 1) chk("flush_v_gated", 32'(btb_v), 32'd0);
      if (cnt == 5) begin
        update_v = 1'b1; update_pc = 32'h0000_001C;
        update_target = 32'h0000_7000; update_type = 2'd1; update_inval = 1'b0;
      end
      if (cnt == 6) update_v = 1'b0;
      if (cnt == rst_at) rst = 1'b1;
    end
    update_v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("flush busy_cycles=%0d", cnt);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; pc = 32'h0000_1000; PHT_pred_taken = 1'b0;
    update_v = 1'b0; update_inval = 1'b0; update_pc = '0;
    update_target = '0; update_type = '0; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    miss("reset", 32'h0000_1000);

    // basic write then hit, target low bits dropped, pred gating
    upd(32'h0000_1004, 32'h0000_2003, 2'b01, 1'b0);
    look("basic_t", 32'h0000_1004, 1'b1, 1'b1, 32'h0000_2000, 2'b01, 1'b0);
    look("basic_nt", 32'h0000_1004, 1'b0, 1'b1, 32'h0000_2000, 2'b01, 1'b0);

    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    miss("post_rst", 32'h0000_1004);

    // replacement in set 1
    upd(32'h0000_0104, 32'h0000_A000, 2'd0, 1'b0);   // A -> way0
    upd(32'h0000_4104, 32'h0000_B000, 2'd1, 1'b0);   // B -> way1
    look("A_w0", 32'h0000_0104, 1'b1, 1'b1, 32'h0000_A000, 2'd0, 1'b0);
    look("B_w1", 32'h0000_4104, 1'b1, 1'b1, 32'h0000_B000, 2'd1, 1'b1);
    upd(32'h0000_8104, 32'h0000_C000, 2'd2, 1'b0);   // C replaces way0, rr->1
    miss("A_evict", 32'h0000_0104);
    look("B_keep", 32'h0000_4104, 1'b1, 1'b1, 32'h0000_B000, 2'd1, 1'b1);
    look("C_w0", 32'h0000_8104, 1'b1, 1'b1, 32'h0000_C000, 2'd2, 1'b0);
    upd(32'h0000_C104, 32'h0000_D000, 2'd3, 1'b0);   // D replaces way1, rr->0
    miss("B_evict", 32'h0000_4104);
    look("C_keep", 32'h0000_8104, 1'b1, 1'b1, 32'h0000_C000, 2'd2, 1'b0);
    look("D_w1", 32'h0000_C104, 1'b1, 1'b1, 32'h0000_D000, 2'd3, 1'b1);
    upd(32'h0000_8104, 32'h0000_E000, 2'd1, 1'b0);   // hit overwrite, rr stays 0
    look("C_upd", 32'h0000_8104, 1'b1, 1'b1, 32'h0000_E000, 2'd1, 1'b0);
    upd(32'h0001_0104, 32'h0000_F000, 2'd0, 1'b0);   // E replaces way0
    look("E_w0", 32'h0001_0104, 1'b1, 1'b1, 32'h0000_F000, 2'd0, 1'b0);
    look("D_keep", 32'h0000_C104, 1'b1, 1'b1, 32'h0000_D000, 2'd3, 1'b1);

    // same-cycle update and lookup, then invalidate
    update_v = 1'b1; update_pc = 32'h0000_2014; update_target = 32'h0000_3000;
    update_type = 2'd2; update_inval = 1'b0;
    miss("X_same", 32'h0000_2014);
    update_v = 1'b0;
    look("X_next", 32'h0000_2014, 1'b1, 1'b1, 32'h0000_3000, 2'd2, 1'b0);
    upd(32'h0000_6014, 32'h0, 2'd0, 1'b1);           // invalidate on miss: no effect
    look("X_keep", 32'h0000_2014, 1'b1, 1'b1, 32'h0000_3000, 2'd2, 1'b0);
    upd(32'h0000_2014, 32'h0, 2'd0, 1'b1);
    miss("X_inval", 32'h0000_2014);

    // flush sweep
    upd(32'h0000_0008, 32'h0000_4000, 2'd1, 1'b0);
    upd(32'h0000_000C, 32'h0000_5000, 2'd2, 1'b0);
    upd(32'h0000_0010, 32'h0000_6000, 2'd3, 1'b0);
    look("pre_fl", 32'h0000_0008, 1'b1, 1'b1, 32'h0000_4000, 2'd1, 1'b0);
    pc = 32'h0000_000C; PHT_pred_taken = 1'b1;
    flush_req = 1'b1; update_v = 1'b1; update_pc = 32'h0000_0018;
    update_target = 32'h0000_8000; update_type = 2'd1; update_inval = 1'b0;
    @(posedge clk); #1;
    flush_req = 1'b0; update_v = 1'b0;
    flush_run(1000, cnt);
    chk("flush_len", 32'(cnt), 32'd64);
    miss("fl_s2", 32'h0000_0008);
    miss("fl_s3", 32'h0000_000C);
    miss("fl_s4", 32'h0000_0010);
    miss("fl_same", 32'h0000_0018);
    miss("fl_drop", 32'h0000_001C);
    miss("fl_s1", 32'h0000_8104);

    // reset in the middle of a sweep
    upd(32'h0000_0008, 32'h0000_4000, 2'd1, 1'b0);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    flush_run(10, cnt);
    chk("rst_flush_len", 32'(cnt), 32'd10);
    miss("rst_fl", 32'h0000_0008);
    upd(32'h0000_0020, 32'h0000_4441, 2'd1, 1'b0);
    look("after_rst", 32'h0000_0020, 1'b1, 1'b1, 32'h0000_4440, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
